cmd_parser_mc: RTL
==================

Name: cmd_parser_mc

Overview:
- Multi-channel successor of the single-channel UART command parser.
- Collects ASCII bytes from the UART RX into a line buffer of parametrised depth. On CR/LF it decodes one of four commands: DC, RD, EN, ST. It updates per-channel duty/enable registers and streams an ASCII reply to the UART TX.
- Sits between uart_rx/uart_tx and the NCH-channel PWM bank.

Parameters:
- NCH, 4, number of PWM channels (1..10; channel index is one decimal digit).
- MAXLEN, 32, line buffer depth in bytes (8..64).
- DUTY_W, 7, duty register width per channel.
- CASE_INS, 1, 1 = command letters are case-insensitive; 0 = uppercase only.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_byte  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- tx_ready  in  1  UART TX can accept a byte
- tx_valid  out  1  tx_byte valid; held until accepted
- tx_byte  out  8  reply byte
- duty_flat  out  NCH*DUTY_W  channel c duty at [c*DUTY_W +: DUTY_W]
- ch_en  out  NCH  per-channel enable
- busy  out  1  high in PARSE or RESP
- buffer_full  out  1  line reached MAXLEN bytes; sticky until terminator
- eostr_flag  out  1  one-cycle pulse when a terminator is accepted in COLLECT
- drop_cnt  out  8  saturating count of bytes dropped while busy

Behaviour:
- Reset (async, rstn=0) clears all outputs, state and buffer. Reset values: tx_valid=0, tx_byte=0, duty_flat=0, ch_en=0, busy=0, buffer_full=0, eostr_flag=0, drop_cnt=0. Reset mid-reply aborts the reply immediately; no partial byte is held.
- States: COLLECT -> PARSE -> RESP -> COLLECT.
- COLLECT:
  - A non-terminator rx byte with len<MAXLEN is stored at buf[len], then len++.
  - A byte arriving at len==MAXLEN sets buffer_full and is discarded.
  - CR (0x0D) or LF (0x0A) pulses eostr_flag. If len==0 and buffer_full==0 the terminator is ignored, so CRLF pairs and blank lines produce no reply. Otherwise go to PARSE.
- PARSE: exactly one cycle.
  - When CASE_INS=1, letters are folded to uppercase before matching.
  - Decode rules (c = ASCII digit, value must be < NCH; d = ASCII digit):
    - "DCcdd" (len 5): duty[c] = 10*d1 + d0, range 0..99, zero-extended to DUTY_W. Reply OK.
    - "RDc" (len 3): reply "DCcdd\r\n", duty as two decimal digits.
    - "ENcb" (len 4): b is '0' or '1'; ch_en[c] = b. Reply OK.
    - "ST" (len 2): reply one ASCII hex digit of ch_en[3:0] (upper bits ignored when NCH>4), then CRLF.
  - Any other length, unknown opcode, non-digit, out-of-range channel, or buffer_full=1 replies ERR with no register change.
  - Register updates take effect on the PARSE->RESP clock edge.
- RESP:
  - Reply strings: OK = "OK\r\n"; ERR = "ERR\r\n".
  - tx_valid rises in the first RESP cycle, which is 2 cycles after the terminator's rx_valid.
  - A byte transfers when tx_valid && tx_ready. The next byte is presented in the following cycle. tx_byte must not change while tx_valid=1 and tx_ready=0.
  - After the last byte is accepted, go to COLLECT. On that edge: len=0, buffer_full=0, tx_valid=0.
- busy=1 in PARSE and RESP. rx_valid while busy drops the byte and increments drop_cnt (saturates at 255); the dropped byte is not buffered.
- A terminator and a buffer write never occur in the same cycle, because rx_valid carries a single byte.
- Duty arithmetic: 10*d1+d0 is computed in 7 bits. The RD reply uses the stored value, which is always <=99, so the two-digit conversion is exact.

Test Plan:
- Send "DC275\r" (NCH=4) -> duty_flat[20:14]=75, reply "OK\r\n". First tx_valid 2 cycles after the CR strobe. Trailing LF alone produces no reply.
- Send "dc103\n" then "RD1\n" with CASE_INS=1 -> duty ch1=3, replies "OK\r\n" then "DC103\r\n". With CASE_INS=0 the first command -> "ERR\r\n", duty unchanged.
- Send "EN31\r", "EN01\r", then "ST\r" -> ch_en=4'b1001, final reply "9\r\n". "EN41\r" -> "ERR\r\n", ch_en unchanged.
- Send 40 non-terminator bytes, then CR, MAXLEN=32 -> buffer_full=1 from the 33rd byte, reply "ERR\r\n", buffer_full=0 after the last reply byte.
- Hold tx_ready low 10 cycles during a reply and inject 3 rx_valid bytes -> tx_byte stable while stalled, drop_cnt=3, reply completes intact.
- Assert rstn=0 mid-reply -> all outputs 0 asynchronously. After release, "ST\r" replies "0\r\n".

Source files
------------

// File: rtl/cmd_parser_mc_if.sv
// UART-side byte bus of the multi-channel command parser.
// master = the side that drives received bytes and TX readiness;
// slave  = the parser, which answers with reply bytes.
interface cmd_parser_mc_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_byte;

  modport master (
    output rx_byte, rx_valid, tx_ready,
    input  tx_valid, tx_byte
  );

  modport slave (
    input  rx_byte, rx_valid, tx_ready,
    output tx_valid, tx_byte
  );
endinterface

// File: rtl/cmd_parser_mc.sv
// Multi-channel UART command parser.
// Collects a line of ASCII bytes, decodes DCcdd / RDc / ENcb / ST on CR or LF,
// updates per-channel duty and enable registers and streams an ASCII reply.
// DUTY_W must be at least 7 so that 0..99 fits.
module cmd_parser_mc #(
  parameter int NCH      = 4,
  parameter int MAXLEN   = 32,
  parameter int DUTY_W   = 7,
  parameter int CASE_INS = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  cmd_parser_mc_if.slave        bus,
  output logic [NCH*DUTY_W-1:0] duty_flat,
  output logic [NCH-1:0]        ch_en,
  output logic                  busy,
  output logic                  buffer_full,
  output logic                  eostr_flag,
  output logic [7:0]            drop_cnt
);

  localparam int LW = $clog2(MAXLEN + 1);
  localparam logic [LW-1:0] MAXLEN_L = LW'(MAXLEN);
  localparam logic [3:0]    NCH_L    = 4'(NCH);

  typedef enum logic [1:0] {COLLECT = 2'd0, PARSE = 2'd1, RESP = 2'd2} state_t;

  state_t               state_r, state_n;
  logic [7:0]           buf_r [MAXLEN];
  logic [LW-1:0]        len_r;
  logic                 buffer_full_r;
  logic                 eostr_r;
  logic                 busy_r;
  logic [7:0]           drop_cnt_r;
  logic [NCH*DUTY_W-1:0] duty_r;
  logic [NCH-1:0]       ch_en_r;
  logic                 tx_valid_r;
  logic [7:0]           tx_byte_r;
  logic [7:0]           resp_r [7];
  logic [2:0]           resp_len_r;
  logic [2:0]           resp_idx_r;

  // decode results
  logic [7:0]        b0_s, b1_s, b2_s, b3_s, b4_s;
  logic [3:0]        ch_s;
  logic              ch_ok_s;
  logic [6:0]        dv_s;
  logic [DUTY_W-1:0] sel_duty_s;
  logic [6:0]        v7_s, tens_s, ones_s;
  logic [3:0]        st_nib_s;
  logic [7:0]        hex_s;
  logic              dc_ok_s, rd_ok_s, en_ok_s, st_ok_s;
  logic              upd_duty_s, upd_en_s;
  logic [7:0]        resp_s [7];
  logic [2:0]        resp_len_s;
  logic              is_term_s;
  logic              last_s;

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (CASE_INS != 32'sd0 && b >= 8'h61 && b <= 8'h7A) fold = b - 8'h20;
    else fold = b;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    is_digit = (b >= 8'h30) && (b <= 8'h39);
  endfunction

  assign is_term_s = (bus.rx_byte == 8'h0D) || (bus.rx_byte == 8'h0A);
  assign last_s    = (resp_idx_r == (resp_len_r - 3'd1));

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= COLLECT;
    else       state_r <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      COLLECT: begin
        if (bus.rx_valid && is_term_s && ((len_r != {LW{1'b0}}) || buffer_full_r)) state_n = PARSE;
        else state_n = COLLECT;
      end
      PARSE: state_n = RESP;
      RESP: begin
        if (tx_valid_r && bus.tx_ready && last_s) state_n = COLLECT;
        else state_n = RESP;
      end
      default: state_n = COLLECT;
    endcase
  end

  // Command decode and reply construction from the collected line
  always_comb begin
    b0_s = fold(buf_r[0]);
    b1_s = fold(buf_r[1]);
    b2_s = fold(buf_r[2]);
    b3_s = fold(buf_r[3]);
    b4_s = fold(buf_r[4]);
    ch_s    = b2_s[3:0];
    ch_ok_s = is_digit(b2_s) && (ch_s < NCH_L);
    dv_s    = ({3'b000, b3_s[3:0]} * 7'd10) + {3'b000, b4_s[3:0]};

    sel_duty_s = {DUTY_W{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      sel_duty_s = sel_duty_s | ({DUTY_W{4'(c) == ch_s}} & duty_r[c*DUTY_W +: DUTY_W]);
    end
    v7_s   = sel_duty_s[6:0];
    tens_s = v7_s / 7'd10;
    ones_s = v7_s % 7'd10;

    st_nib_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      st_nib_s[i] = (i < NCH) ? ch_en_r[i % NCH] : 1'b0;
    end
    hex_s = (st_nib_s < 4'd10) ? (8'h30 + {4'h0, st_nib_s}) : (8'h37 + {4'h0, st_nib_s});

    dc_ok_s = (len_r == LW'(3'd5)) && (b0_s == 8'h44) && (b1_s == 8'h43) && ch_ok_s
              && is_digit(b3_s) && is_digit(b4_s);
    rd_ok_s = (len_r == LW'(3'd3)) && (b0_s == 8'h52) && (b1_s == 8'h44) && ch_ok_s;
    en_ok_s = (len_r == LW'(3'd4)) && (b0_s == 8'h45) && (b1_s == 8'h4E) && ch_ok_s
              && ((b3_s == 8'h30) || (b3_s == 8'h31));
    st_ok_s = (len_r == LW'(3'd2)) && (b0_s == 8'h53) && (b1_s == 8'h54);

    upd_duty_s = 1'b0;
    upd_en_s   = 1'b0;
    for (int i = 0; i < 7; i++) resp_s[i] = 8'h00;
    // "ERR\r\n" unless a valid command overrides it
    resp_s[0] = 8'h45; resp_s[1] = 8'h52; resp_s[2] = 8'h52;
    resp_s[3] = 8'h0D; resp_s[4] = 8'h0A;
    resp_len_s = 3'd5;

    if (buffer_full_r) begin
      resp_len_s = 3'd5;
    end else if (dc_ok_s || en_ok_s) begin
      upd_duty_s = dc_ok_s;
      upd_en_s   = en_ok_s;
      resp_s[0] = 8'h4F; resp_s[1] = 8'h4B; resp_s[2] = 8'h0D; resp_s[3] = 8'h0A;
      resp_s[4] = 8'h00;
      resp_len_s = 3'd4;
    end else if (rd_ok_s) begin
      resp_s[0] = 8'h44; resp_s[1] = 8'h43; resp_s[2] = b2_s;
      resp_s[3] = 8'h30 + {1'b0, tens_s};
      resp_s[4] = 8'h30 + {1'b0, ones_s};
      resp_s[5] = 8'h0D; resp_s[6] = 8'h0A;
      resp_len_s = 3'd7;
    end else if (st_ok_s) begin
      resp_s[0] = hex_s; resp_s[1] = 8'h0D; resp_s[2] = 8'h0A;
      resp_s[3] = 8'h00; resp_s[4] = 8'h00;
      resp_len_s = 3'd3;
    end else begin
      resp_len_s = 3'd5;
    end
  end

  // Line buffer, register file, reply streaming and status flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAXLEN; i++) buf_r[i] <= 8'h00;
      for (int i = 0; i < 7; i++) resp_r[i] <= 8'h00;
      len_r         <= {LW{1'b0}};
      buffer_full_r <= 1'b0;
      eostr_r       <= 1'b0;
      busy_r        <= 1'b0;
      drop_cnt_r    <= 8'h00;
      duty_r        <= {(NCH*DUTY_W){1'b0}};
      ch_en_r       <= {NCH{1'b0}};
      tx_valid_r    <= 1'b0;
      tx_byte_r     <= 8'h00;
      resp_len_r    <= 3'd0;
      resp_idx_r    <= 3'd0;
    end else begin
      eostr_r <= 1'b0;
      busy_r  <= (state_n != COLLECT);
      case (state_r)
        COLLECT: begin
          if (bus.rx_valid) begin
            if (is_term_s) begin
              eostr_r <= 1'b1;
            end else if (len_r < MAXLEN_L) begin
              for (int i = 0; i < MAXLEN; i++) begin
                if (len_r == LW'(i)) buf_r[i] <= bus.rx_byte;
              end
              len_r <= len_r + LW'(1'b1);
            end else begin
              buffer_full_r <= 1'b1;
            end
          end
        end
        PARSE: begin
          if (bus.rx_valid && drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
          for (int i = 0; i < 7; i++) resp_r[i] <= resp_s[i];
          resp_len_r <= resp_len_s;
          resp_idx_r <= 3'd0;
          tx_byte_r  <= resp_s[0];
          tx_valid_r <= 1'b1;
          for (int c = 0; c < NCH; c++) begin
            if (upd_duty_s && 4'(c) == ch_s) duty_r[c*DUTY_W +: DUTY_W] <= DUTY_W'(dv_s);
            if (upd_en_s && 4'(c) == ch_s) ch_en_r[c] <= b3_s[0];
          end
        end
        RESP: begin
          if (bus.rx_valid && drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
          if (tx_valid_r && bus.tx_ready) begin
            if (last_s) begin
              tx_valid_r    <= 1'b0;
              tx_byte_r     <= 8'h00;
              len_r         <= {LW{1'b0}};
              buffer_full_r <= 1'b0;
            end else begin
              resp_idx_r <= resp_idx_r + 3'd1;
              tx_byte_r  <= resp_r[resp_idx_r + 3'd1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_byte  = tx_byte_r;
  assign duty_flat    = duty_r;
  assign ch_en        = ch_en_r;
  assign busy         = busy_r;
  assign buffer_full  = buffer_full_r;
  assign eostr_flag   = eostr_r;
  assign drop_cnt     = drop_cnt_r;

endmodule
